// File: rtl/pipeline_pkg.sv
// Core-wide shared types: datapath width and the memory arbiter state encoding.
package pipeline;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} arb_state_e;
endpackage

// File: rtl/mem_arbiter.sv
// Shares the single external memory port between instruction fetch and the LSU.
// Data has priority; a streak counter bounds consecutive data grants so fetch always progresses.
module mem_arbiter
  import pipeline::*;
#(
  parameter int STREAK_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_re,
  input  logic [XLEN-1:0] i_addr,
  input  logic [3:0]      i_sel,
  output logic [31:0]     i_data,
  output logic            i_ack,
  input  logic            d_re,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [3:0]      d_sel,
  input  logic [31:0]     d_wdata,
  output logic [31:0]     d_rdata,
  output logic            d_ack,
  output logic            mem_re,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_sel,
  output logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_rdata,
  input  logic            mem_ack
);
  localparam int       SW  = $clog2(STREAK_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STREAK_LIMIT);

  arb_state_e      state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            d_req, decide;

  assign d_req  = d_re | d_we;
  // A new grant is chosen from IDLE or on the completing cycle, so transactions abut.
  assign decide = (state_q == IDLE) | mem_ack;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    if (decide) begin
      if (d_req && streak_q < LIM) state_d = GNT_D;
      else if (i_re)               state_d = GNT_I;
      else if (d_req)              state_d = GNT_D;
      else                         state_d = IDLE;
    end
    if (!i_re)
      streak_d = '0;
    else if (decide && state_d == GNT_I)
      streak_d = '0;
    else if (decide && state_d == GNT_D && streak_q != LIM)
      streak_d = streak_q + SW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_sel   = '0;
    mem_wdata = '0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    case (state_q)
      GNT_I: begin
        mem_re   = i_re;
        mem_addr = i_addr;
        mem_sel  = i_sel;
        i_ack    = mem_ack;
      end
      GNT_D: begin
        mem_re    = d_re;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_sel   = d_sel;
        mem_wdata = d_wdata;
        d_ack     = mem_ack;
      end
      default: ;
    endcase
  end

  // Read data is qualified only by the ack, so no steering is needed.
  assign i_data  = mem_rdata;
  assign d_rdata = mem_rdata;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the core's single external memory port between instruction fetch (read-only) and the load/store unit (read/write). Sits between the IFU/LSU bus ports and the memory bus, serialising transactions and holding each grant until the memory acknowledges. Data accesses have priority, and a streak counter guarantees that fetch is never starved.

## Interface
Parameters:
- `STREAK_LIMIT`, default 4: maximum number of consecutive data grants while fetch is waiting; minimum 1.
- `XLEN`: taken from `pipeline::XLEN`, default 32.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_re`  in  1  fetch read request.
- `i_addr`  in  XLEN  fetch address.
- `i_sel`  in  4  fetch byte select.
- `i_data`  out  32  fetch read data.
- `i_ack`  out  1  fetch transaction complete.
- `d_re`  in  1  data read request.
- `d_we`  in  1  data write request; `d_re` and `d_we` are never both high.
- `d_addr`  in  XLEN  data address.
- `d_sel`  in  4  data byte select.
- `d_wdata`  in  32  store data.
- `d_rdata`  out  32  load data.
- `d_ack`  out  1  data transaction complete.
- `mem_re`, `mem_we`  out  1  memory strobes.
- `mem_addr`  out  XLEN  memory address.
- `mem_sel`  out  4  memory byte select.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data.
- `mem_ack`  in  1  memory completion; arrives 1 or more cycles after the strobe is asserted.

## Operation
FSM states are `IDLE`, `GNT_I`, and `GNT_D`.

Arbitration decision, taken in `IDLE` and on any cycle with `mem_ack` in a grant state:
- Data request (`d_re|d_we`) and `streak < STREAK_LIMIT`: next state is `GNT_D`.
- Otherwise, if `i_re`: next state is `GNT_I`.
- Otherwise, if a data request is present: next state is `GNT_D`.
- Otherwise: next state is `IDLE`.

`streak` counter:
- Increments on each `GNT_D` entry while `i_re` is high.
- Clears on `GNT_I` entry or when `i_re` is low.
- Saturates at `STREAK_LIMIT`.

In `GNT_x`:
- The `mem_*` outputs mirror the granted master's live inputs.
- The other master's ack is held at 0.

Ack and data routing:
- `mem_ack` is routed combinationally to the granted master's ack.
- `i_data` and `d_rdata` both carry `mem_rdata` unconditionally; they are qualified only by the ack.
- The granted master must hold its request stable until its ack. Dropping the request mid-grant is not supported; the grant still waits for `mem_ack`.

In `IDLE`, all `mem_*` strobes are 0. Address, select and write data are then 0.

## Timing
- Reset values: state `IDLE`, `streak`=0, `mem_re`=`mem_we`=0, `mem_addr`/`mem_sel`/`mem_wdata`=0, `i_ack`=`d_ack`=0.
- Reset asserted mid-transaction: strobes drop asynchronously in the same cycle. Any later `mem_ack` is ignored.
- Grant latency: a request seen in `IDLE` in cycle N drives the memory strobe from cycle N+1.
- Back-to-back: on a `mem_ack` cycle the next grant is decided in that cycle and the new strobe is driven in cycle N+1, so there are no dead cycles between transactions.
- Simultaneous first requests from `IDLE`: data wins.
- `STREAK_LIMIT`=1 gives strict alternation whenever both masters are requesting.
- A `mem_ack` in `IDLE` is ignored: no ack is forwarded.

## Structure
- Add the state enum `arb_state_e {IDLE, GNT_I, GNT_D}` to the `pipeline` package, alongside `XLEN`.
- Single module with no sub-modules. Arbitration is a combinational next-state block plus registered state and `streak`.
- The `mem_*` mux is combinational on the state.

## Test plan
- **Reset:** assert `reset` with `i_re`=1 -> all `mem_*`=0 and acks 0. Deassert -> `mem_re`=1 and `mem_addr`=`i_addr` one cycle later.
- **Priority:** in `IDLE`, `i_re`=1 and `d_we`=1 with `d_addr`=0x100 and `d_wdata`=0xDEADBEEF -> memory sees the write first. After `mem_ack`, `d_ack` pulses once and the fetch is granted the next cycle.
- **Anti-starvation:** with `STREAK_LIMIT`=4, `d_re` held high and `i_re` held high, `mem_ack` every 2 cycles -> grant order is D,D,D,D,I,D,D,D,D,I.
- **Latency hold:** hold `mem_ack` off for 7 cycles during `GNT_I` -> `mem_*` stable for all 7 cycles, `d_ack`=0 throughout, and `i_ack` pulses exactly once with `i_data`=`mem_rdata`.
- **Mid-transaction reset:** assert `reset` in cycle 2 of a `GNT_D` store -> `mem_we`=0 the same cycle, and a `mem_ack` one cycle later produces no `d_ack`.
- **Idle spurious ack:** `mem_ack`=1 with no requests -> both acks stay 0 and the state stays `IDLE`.
